// File: rtl/bus_cycle_ctrl.sv
// Bus cycle sequencer for a bidirectional tristate transceiver: drives dir/g_
// and the A side with programmable setup, hold, turnaround, wait states and timeout.
module bus_cycle_ctrl #(
    parameter int WIDTH = 8,
    parameter int SETUP = 1,
    parameter int HOLD  = 1,
    parameter int TURN  = 1,
    parameter int TMO   = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic             we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             ack,
    output logic             err,
    output logic [WIDTH-1:0] rdata,
    output logic [WIDTH-1:0] a_o,
    output logic             a_oe,
    input  logic [WIDTH-1:0] a_i,
    output logic             dir,
    output logic             g_,
    input  logic             rdy
);

    localparam int M1   = (SETUP > HOLD) ? SETUP : HOLD;
    localparam int M2   = (TURN > TMO) ? TURN : TMO;
    localparam int CMAX = (M1 > M2) ? M1 : M2;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [CW-1:0] SETUP_LAST = CW'((SETUP > 0) ? SETUP - 1 : 0);
    localparam logic [CW-1:0] HOLD_LAST  = CW'((HOLD > 0) ? HOLD - 1 : 0);
    localparam logic [CW-1:0] TURN_LAST  = CW'((TURN > 0) ? TURN - 1 : 0);
    localparam logic [CW-1:0] TMO_LAST   = CW'(TMO - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACTIVE,
        S_HOLD,
        S_TURN
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             we_q, we_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic             err_pend_q, err_pend_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic [WIDTH-1:0] a_o_q, a_o_d;
    logic             a_oe_q, a_oe_d;
    logic             dir_q, dir_d;
    logic             g_q, g_d;
    logic             busy_q, busy_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;

    logic             end_strobe;
    logic             end_err;
    logic             drive;

    always_comb begin
        // NOTE: every variable gets a default first so no path through the case infers a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        err_pend_d = err_pend_q;
        rdata_d    = rdata_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        end_strobe = 1'b0;
        end_err    = err_pend_q;

        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    we_d       = we;
                    wdata_d    = wdata;
                    err_pend_d = 1'b0;
                    cnt_d      = '0;
                    state_d    = (SETUP > 0) ? S_SETUP : S_ACTIVE;
                end
            end
            S_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    cnt_d   = '0;
                    state_d = S_ACTIVE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_ACTIVE: begin
                if (rdy || cnt_q == TMO_LAST) begin
                    if (rdy && !we_q) begin
                        rdata_d = a_i;
                    end
                    if (!rdy) begin
                        err_pend_d = 1'b1;
                        end_err    = 1'b1;
                    end
                    cnt_d = '0;
                    if (HOLD > 0) begin
                        state_d = S_HOLD;
                    end else begin
                        end_strobe = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d      = '0;
                    end_strobe = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_TURN: begin
                if (cnt_q == TURN_LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // The ack cycle is the first one after the strobe (and hold) ends.
        if (end_strobe) begin
            ack_d   = 1'b1;
            err_d   = end_err;
            state_d = (TURN > 0) ? S_TURN : S_IDLE;
        end

        // NOTE: outputs are decoded from state_d and flopped, so each registered
        // output lines up with the state it belongs to rather than lagging a cycle.
        drive  = (state_d == S_SETUP) || (state_d == S_ACTIVE) || (state_d == S_HOLD);
        g_d    = (state_d != S_ACTIVE);
        dir_d  = drive & we_d;
        a_oe_d = drive & we_d;
        a_o_d  = drive ? wdata_d : a_o_q;
        busy_d = (state_d != S_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            err_pend_q <= 1'b0;
            rdata_q    <= '0;
            a_o_q      <= '0;
            a_oe_q     <= 1'b0;
            dir_q      <= 1'b0;
            g_q        <= 1'b1;
            busy_q     <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            err_pend_q <= err_pend_d;
            rdata_q    <= rdata_d;
            a_o_q      <= a_o_d;
            a_oe_q     <= a_oe_d;
            dir_q      <= dir_d;
            g_q        <= g_d;
            busy_q     <= busy_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
        end
    end

    assign busy  = busy_q;
    assign ack   = ack_q;
    assign err   = err_q;
    assign rdata = rdata_q;
    assign a_o   = a_o_q;
    assign a_oe  = a_oe_q;
    assign dir   = dir_q;
    assign g_    = g_q;

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Self-checking bench for bus_cycle_ctrl: default-timing instance plus a
// zero setup/hold/turn instance, with an ack-driven scoreboard per instance.
module tb_bus_cycle_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         req, req_z, we, rdy;
    logic [W-1:0] wdata, a_i;

    logic         busy, ack, err, a_oe, dir, g_n;
    logic [W-1:0] rdata, a_o;
    logic         busy_z, ack_z, err_z, a_oe_z, dir_z, g_z;
    logic [W-1:0] rdata_z, a_o_z;

    always #5 clk = ~clk;

    bus_cycle_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .wdata(wdata),
        .busy(busy), .ack(ack), .err(err), .rdata(rdata),
        .a_o(a_o), .a_oe(a_oe), .a_i(a_i), .dir(dir), .g_(g_n), .rdy(rdy)
    );

    bus_cycle_ctrl #(.WIDTH(W), .SETUP(0), .HOLD(0), .TURN(0), .TMO(15)) dut_z (
        .clk(clk), .rst(rst), .req(req_z), .we(we), .wdata(wdata),
        .busy(busy_z), .ack(ack_z), .err(err_z), .rdata(rdata_z),
        .a_o(a_o_z), .a_oe(a_oe_z), .a_i(a_i), .dir(dir_z), .g_(g_z), .rdy(rdy)
    );

    typedef struct packed {
        logic         err;
        logic [W-1:0] rdata;
    } exp_t;

    exp_t         sb[$];
    exp_t         sb_z[$];
    exp_t         e_m, e_z;
    int           n_cmp = 0;
    int           n_bad = 0;
    int           n_ack = 0;
    logic [W-1:0] rdata_model   = '0;
    logic [W-1:0] rdata_model_z = '0;
    logic         p_dir = 1'b0, p_aoe = 1'b0, p_dir_z = 1'b0, p_g_z = 1'b1;

    // Scoreboard and invariant monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (ack) begin
                n_ack++;
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL ack_unexpected: ack=1 with no pending transaction");
                end else begin
                    e_m = sb.pop_front();
                    if ({err, rdata} !== {e_m.err, e_m.rdata}) begin
                        n_bad++;
                        $display("FAIL ack_result: err=%b rdata=%h, need err=%b rdata=%h",
                                 err, rdata, e_m.err, e_m.rdata);
                    end
                end
            end
            if (ack_z) begin
                n_cmp++;
                if (sb_z.size() == 0) begin
                    n_bad++;
                    $display("FAIL ack_z_unexpected: ack=1 with no pending transaction");
                end else begin
                    e_z = sb_z.pop_front();
                    if ({err_z, rdata_z} !== {e_z.err, e_z.rdata}) begin
                        n_bad++;
                        $display("FAIL ack_z_result: err=%b rdata=%h, need err=%b rdata=%h",
                                 err_z, rdata_z, e_z.err, e_z.rdata);
                    end
                end
            end
            n_cmp++;
            if ((err && !ack) || (a_oe && !dir) || (!g_n && (dir !== p_dir || a_oe !== p_aoe))) begin
                n_bad++;
                $display("FAIL invariant: err=%b ack=%b dir=%b(prev %b) a_oe=%b(prev %b) g_=%b",
                         err, ack, dir, p_dir, a_oe, p_aoe, g_n);
            end
            n_cmp++;
            if ((a_oe_z && !dir_z) || (!g_z && !p_g_z && dir_z !== p_dir_z)) begin
                n_bad++;
                $display("FAIL invariant_z: dir=%b(prev %b) a_oe=%b g_=%b(prev %b)",
                         dir_z, p_dir_z, a_oe_z, g_z, p_g_z);
            end
        end
        p_dir   = dir;
        p_aoe   = a_oe;
        p_dir_z = dir_z;
        p_g_z   = g_z;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, need completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int bound);
        int k = 0;
        while (busy !== 1'b0 && k < bound) begin
            tick();
            k++;
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL wait_idle: busy=%b after %0d cycles, need 0", busy, bound);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 1'b0; req_z = 1'b0; we = 1'b0; rdy = 1'b0;
        wdata = '0; a_i = '0;
        tick();
        tick();
        n_cmp++;
        if ({busy, ack, err, dir, a_oe, g_n, a_o, rdata} !== {6'b000001, 8'h00, 8'h00}) begin
            n_bad++;
            $display("FAIL reset_main: busy/ack/err/dir/a_oe/g_=%b%b%b%b%b%b a_o=%h rdata=%h, need 000001 00 00",
                     busy, ack, err, dir, a_oe, g_n, a_o, rdata);
        end
        n_cmp++;
        if ({busy_z, ack_z, dir_z, a_oe_z, g_z, rdata_z} !== {5'b00001, 8'h00}) begin
            n_bad++;
            $display("FAIL reset_zero: busy/ack/dir/a_oe/g_=%b%b%b%b%b rdata=%h, need 00001 00",
                     busy_z, ack_z, dir_z, a_oe_z, g_z, rdata_z);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_write_default();
        we = 1'b1; wdata = 8'hA5; rdy = 1'b1; req = 1'b1;
        sb.push_back(exp_t'{1'b0, rdata_model});
        tick();
        req = 1'b0;
        n_cmp++;
        if ({busy, g_n, dir, a_oe, a_o} !== {4'b1111, 8'hA5}) begin
            n_bad++;
            $display("FAIL write_setup: busy/g_/dir/a_oe=%b%b%b%b a_o=%h, need 1111 a5", busy, g_n, dir, a_oe, a_o);
        end
        tick();
        n_cmp++;
        if ({g_n, dir, a_oe, ack, a_o} !== {4'b0110, 8'hA5}) begin
            n_bad++;
            $display("FAIL write_active: g_/dir/a_oe/ack=%b%b%b%b a_o=%h, need 0110 a5", g_n, dir, a_oe, ack, a_o);
        end
        tick();
        n_cmp++;
        if ({g_n, dir, a_oe, ack, a_o} !== {4'b1110, 8'hA5}) begin
            n_bad++;
            $display("FAIL write_hold: g_/dir/a_oe/ack=%b%b%b%b a_o=%h, need 1110 a5", g_n, dir, a_oe, ack, a_o);
        end
        tick();
        n_cmp++;
        if ({ack, err, busy, dir, a_oe, g_n} !== 6'b101001) begin
            n_bad++;
            $display("FAIL write_turn: ack/err/busy/dir/a_oe/g_=%b%b%b%b%b%b, need 101001", ack, err, busy, dir, a_oe, g_n);
        end
        tick();
        n_cmp++;
        if ({busy, ack} !== 2'b00) begin
            n_bad++;
            $display("FAIL write_idle: busy/ack=%b%b, need 00", busy, ack);
        end
    endtask

    task automatic test_read_wait();
        int gl = 0;
        int k  = 0;
        we = 1'b0; a_i = 8'h3C; rdy = 1'b0; req = 1'b1;
        rdata_model = 8'h3C;
        sb.push_back(exp_t'{1'b0, 8'h3C});
        tick();
        req = 1'b0;
        n_cmp++;
        if ({busy, g_n, dir, a_oe} !== 4'b1100) begin
            n_bad++;
            $display("FAIL read_setup: busy/g_/dir/a_oe=%b%b%b%b, need 1100", busy, g_n, dir, a_oe);
        end
        tick();
        while (g_n === 1'b0 && k < 40) begin
            gl++;
            n_cmp++;
            if ({dir, a_oe} !== 2'b00) begin
                n_bad++;
                $display("FAIL read_release: dir/a_oe=%b%b, need 00", dir, a_oe);
            end
            if (gl == 4) rdy = 1'b1;
            tick();
            k++;
        end
        n_cmp++;
        if (gl != 4) begin
            n_bad++;
            $display("FAIL read_strobe_len: g_ low %0d cycles, need 4", gl);
        end
        n_cmp++;
        if (rdata !== 8'h3C) begin
            n_bad++;
            $display("FAIL read_capture: rdata=%h, need 3c", rdata);
        end
        wait_idle(10);
    endtask

    task automatic test_timeout();
        int gl = 0;
        int k  = 0;
        we = 1'b0; a_i = 8'h77; rdy = 1'b0; req = 1'b1;
        sb.push_back(exp_t'{1'b1, rdata_model});
        tick();
        req = 1'b0;
        tick();
        while (g_n === 1'b0 && k < 40) begin
            gl++;
            tick();
            k++;
        end
        n_cmp++;
        if (gl != 15) begin
            n_bad++;
            $display("FAIL timeout_len: g_ low %0d cycles, need 15", gl);
        end
        n_cmp++;
        if (rdata !== rdata_model) begin
            n_bad++;
            $display("FAIL timeout_rdata: rdata=%h, need %h", rdata, rdata_model);
        end
        tick();
        n_cmp++;
        if ({ack, err} !== 2'b11) begin
            n_bad++;
            $display("FAIL timeout_flag: ack/err=%b%b, need 11", ack, err);
        end
        wait_idle(10);
    endtask

    task automatic test_zero_timing();
        we = 1'b1; wdata = 8'h81; rdy = 1'b1; req_z = 1'b1;
        sb_z.push_back(exp_t'{1'b0, rdata_model_z});
        tick();
        req_z = 1'b0;
        n_cmp++;
        if ({busy_z, g_z, dir_z, a_oe_z, a_o_z} !== {4'b1011, 8'h81}) begin
            n_bad++;
            $display("FAIL zero_write_active: busy/g_/dir/a_oe=%b%b%b%b a_o=%h, need 1011 81",
                     busy_z, g_z, dir_z, a_oe_z, a_o_z);
        end
        tick();
        n_cmp++;
        if ({ack_z, err_z, g_z} !== 3'b101) begin
            n_bad++;
            $display("FAIL zero_write_ack: ack/err/g_=%b%b%b, need 101", ack_z, err_z, g_z);
        end
        tick();
        n_cmp++;
        if (busy_z !== 1'b0) begin
            n_bad++;
            $display("FAIL zero_write_idle: busy=%b, need 0", busy_z);
        end
        we = 1'b0; a_i = 8'h5A; req_z = 1'b1;
        rdata_model_z = 8'h5A;
        sb_z.push_back(exp_t'{1'b0, 8'h5A});
        tick();
        req_z = 1'b0;
        n_cmp++;
        if ({g_z, dir_z, a_oe_z} !== 3'b000) begin
            n_bad++;
            $display("FAIL zero_read_active: g_/dir/a_oe=%b%b%b, need 000", g_z, dir_z, a_oe_z);
        end
        tick();
        n_cmp++;
        if ({ack_z, rdata_z} !== {1'b1, 8'h5A}) begin
            n_bad++;
            $display("FAIL zero_read_ack: ack=%b rdata=%h, need 1 5a", ack_z, rdata_z);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int base  = n_ack;
        int k     = 0;
        logic stray = 1'b0;
        rdy = 1'b1; we = 1'b1; wdata = 8'hC3; req = 1'b1;
        sb.push_back(exp_t'{1'b0, rdata_model});
        tick();
        while (ack !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        n_cmp++;
        if (ack !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_first_ack: ack=%b after %0d cycles, need 1", ack, k);
        end
        we = 1'b0; a_i = 8'hE7;
        rdata_model = 8'hE7;
        sb.push_back(exp_t'{1'b0, 8'hE7});
        tick();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_idle_gap: busy=%b, need 0", busy);
        end
        tick();
        req = 1'b0;
        n_cmp++;
        if ({busy, dir, a_oe} !== 3'b100) begin
            n_bad++;
            $display("FAIL b2b_restart: busy/dir/a_oe=%b%b%b, need 100", busy, dir, a_oe);
        end
        tick();
        req = 1'b1;
        tick();
        req = 1'b0;
        wait_idle(10);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (busy !== 1'b0) stray = 1'b1;
        end
        n_cmp++;
        if (stray !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_ignored_req: extra cycle started=%b, need 0", stray);
        end
        n_cmp++;
        if (n_ack - base != 2 || sb.size() != 0) begin
            n_bad++;
            $display("FAIL b2b_ack_count: acks=%0d pending=%0d, need 2 and 0", n_ack - base, sb.size());
        end
    endtask

    task automatic test_async_reset();
        // The aborted cycle is never acknowledged, so nothing is queued for it.
        we = 1'b1; wdata = 8'h5C; rdy = 1'b0; req = 1'b1;
        tick();
        req = 1'b0;
        tick();
        n_cmp++;
        if (g_n !== 1'b0) begin
            n_bad++;
            $display("FAIL areset_pre: g_=%b, need 0", g_n);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({g_n, a_oe, dir, busy, ack, err, rdata} !== {6'b100000, 8'h00}) begin
            n_bad++;
            $display("FAIL areset_immediate: g_/a_oe/dir/busy/ack/err=%b%b%b%b%b%b rdata=%h, need 100000 00",
                     g_n, a_oe, dir, busy, ack, err, rdata);
        end
        #2 rst = 1'b0;
        rdata_model   = '0;
        rdata_model_z = '0;
        tick();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL areset_no_restart: busy=%b, need 0", busy);
        end
        we = 1'b0; a_i = 8'h96; rdy = 1'b1; req = 1'b1;
        rdata_model = 8'h96;
        sb.push_back(exp_t'{1'b0, 8'h96});
        tick();
        req = 1'b0;
        wait_idle(10);
        n_cmp++;
        if (rdata !== 8'h96) begin
            n_bad++;
            $display("FAIL areset_next_cycle: rdata=%h, need 96", rdata);
        end
    endtask

    initial begin
        test_reset();
        test_write_default();
        test_read_wait();
        test_timeout();
        test_zero_timing();
        test_back_to_back();
        test_async_reset();
        tick();
        n_cmp++;
        if (sb.size() != 0 || sb_z.size() != 0) begin
            n_bad++;
            $display("FAIL pending_acks: main=%0d zero=%0d outstanding, need 0 and 0", sb.size(), sb_z.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
